uart_tx_arbiter: RTL

//  Shares one 8N1 UART transmit line between NUM_REQ byte requesters.

---
 rtl/uart_tx_arbiter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that shares one 8N1 UART transmit line
// between NUM_REQ byte requesters. One byte is granted per frame, then it is
// serialized LSB-first as start(0), 8 data bits, stop(1), BAUD_CNT clocks per bit.
module uart_tx_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int BAUD_CNT = 5208
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] din,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [2:0]           gnt_id,
    output logic                 busy,
    output logic                 tx_uart
);

    localparam int CW = (BAUD_CNT > 1) ? $clog2(BAUD_CNT) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt0;
    logic [3:0]    cnt1;
    logic [7:0]    shift;
    logic [2:0]    last;
    logic          bit_end;
    logic          found;
    logic [2:0]    winner;
    logic [7:0]    sel_byte;
    logic          grant_ok;
    logic          tx_next;

    assign bit_end = (cnt0 == CW'(BAUD_CNT - 1));

    // Round-robin search: the first set request after the last winner wins.
    always_comb begin
        found  = 1'b0;
        winner = last;
        for (int k = 1; k <= NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found && req[i] && (i == (int'(last) + k) % NUM_REQ)) begin
                    found  = 1'b1;
                    winner = 3'(i);
                end
            end
        end
    end

    // Pick the winner's byte and drive its one-hot grant pulse.
    always_comb begin
        sel_byte = 8'h00;
        gnt      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (3'(i) == winner) begin
                sel_byte = din[8*i +: 8];
                gnt[i]   = grant_ok;
            end
        end
    end

    // Next-state decode and the value the registered line takes next clock.
    always_comb begin
        state_next = state;
        tx_next    = tx_uart;
        grant_ok   = 1'b0;
        case (state)
            IDLE: begin
                tx_next = 1'b1;
                if (found && rst_n) begin
                    grant_ok   = 1'b1;
                    state_next = START;
                    tx_next    = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_next = DATA;
                    tx_next    = shift[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (cnt1 == 4'd8) begin
                        state_next = STOP;
                        tx_next    = 1'b1;
                    end else begin
                        tx_next = shift[1];
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_next = IDLE;
                    tx_next    = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                tx_next    = 1'b1;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Baud counter and completed-bit counter, both parked at zero while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0 <= '0;
            cnt1 <= 4'd0;
        end else if (state == IDLE) begin
            cnt0 <= '0;
            cnt1 <= 4'd0;
        end else if (bit_end) begin
            cnt0 <= '0;
            cnt1 <= (cnt1 == 4'd9) ? 4'd0 : cnt1 + 4'd1;
        end else begin
            cnt0 <= cnt0 + CW'(1);
        end
    end

    // Grant bookkeeping: latch the byte, remember the winner, shift data bits out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift  <= 8'h00;
            last   <= 3'(NUM_REQ - 1);
            gnt_id <= 3'd0;
        end else if (grant_ok) begin
            shift  <= sel_byte;
            last   <= winner;
            gnt_id <= winner;
        end else if ((state == DATA) && bit_end) begin
            shift <= {1'b0, shift[7:1]};
        end
    end

    // Registered line and busy flag, so nothing on req reaches tx_uart combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_uart <= 1'b1;
            busy    <= 1'b0;
        end else begin
            tx_uart <= tx_next;
            busy    <= (state_next != IDLE);
        end
    end

endmodule
